// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the 16-bit CPU front end: instruction memory port,
// the decode handshake and the execute-stage redirect/halt controls.
interface fetch_sequencer_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt;
    logic [15:0] accept_count;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, accept_count,
        input  imem_data, if_ready, redirect_valid, redirect_target, halt
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, accept_count,
        output imem_data, if_ready, redirect_valid, redirect_target, halt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives a 1-cycle-latency instruction
// memory and hands PC-tagged words to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    fetch_sequencer_if.master bus
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_valid_q, inflight_valid_d;
    logic [15:0] accept_count_q, accept_count_d;
    logic        stall;
    logic        if_valid;

    // A stalled word is held by re-reading its own address every cycle.
    assign stall         = inflight_valid_q && !bus.if_ready;
    assign if_valid      = inflight_valid_q && (state_q == ST_RUN) &&
                           !bus.redirect_valid && !reset_i;
    assign bus.if_valid  = if_valid;
    assign bus.imem_addr = reset_i ? RESET_PC :
                           (stall ? inflight_pc_q : fetch_pc_q);
    assign bus.if_instr  = bus.imem_data;
    assign bus.if_pc     = inflight_pc_q;
    assign bus.accept_count = accept_count_q;

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        accept_count_d   = accept_count_q;

        if (if_valid && bus.if_ready) begin
            accept_count_d = accept_count_q + 16'd1;
        end

        if (bus.redirect_valid) begin
            fetch_pc_d       = bus.redirect_target;
            inflight_valid_d = 1'b0;
            state_d          = ST_RUN;
        end else if (bus.halt) begin
            state_d          = ST_HALT;
            inflight_valid_d = 1'b0;
        end else if (state_q == ST_RUN && !stall) begin
            inflight_pc_d    = fetch_pc_q;
            inflight_valid_d = 1'b1;
            fetch_pc_d       = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_RUN;
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= 16'h0000;
            inflight_valid_q <= 1'b0;
            accept_count_q   <= 16'h0000;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            accept_count_q   <= accept_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected accepted PCs are queued as
// stimulus is driven and popped whenever decode takes an instruction.
module tb_fetch_sequencer;

    logic clk;
    logic reset;
    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sbQueue[$];
    logic [15:0] modelCount = 16'h0000;
    logic        primed = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) bus.imem_data <= memWord(bus.imem_addr);

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic monitor();
        logic [15:0] expPc;
        logic        fire;
        fire = bus.if_valid && bus.if_ready;
        if (primed) checkOutput("accept_count", bus.accept_count, modelCount);
        if (fire) begin
            expPc = (sbQueue.size() > 0) ? sbQueue.pop_front() : 16'hxxxx;
            checkOutput("if_pc", bus.if_pc, expPc);
            checkOutput("if_instr", bus.if_instr, memWord(expPc));
        end
        if (reset) begin
            modelCount = 16'h0000;
            primed     = 1'b1;
        end else if (fire) begin
            modelCount = modelCount + 16'd1;
        end
    endtask

    // Drive one cycle of inputs just after the edge, then observe at negedge.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                                 input logic [15:0] tgt, input logic hlt);
        @(posedge clk);
        #1;
        reset               = rst;
        bus.if_ready        = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.halt            = hlt;
        @(negedge clk);
        monitor();
    endtask

    initial begin
        reset               = 1'b1;
        bus.if_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 16'h0000;
        bus.halt            = 1'b0;

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset_valid", {15'd0, bus.if_valid}, 16'h0000);
        checkOutput("reset_addr", bus.imem_addr, 16'h0000);

        sbQueue.push_back(16'h0000);
        sbQueue.push_back(16'h0002);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("first_bubble", {15'd0, bus.if_valid}, 16'h0000);
        checkOutput("first_addr", bus.imem_addr, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("first_valid", {15'd0, bus.if_valid}, 16'h0001);
        checkOutput("second_addr", bus.imem_addr, 16'h0002);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            checkOutput("stall_valid", {15'd0, bus.if_valid}, 16'h0001);
            checkOutput("stall_pc", bus.if_pc, 16'h0004);
            checkOutput("stall_addr", bus.imem_addr, 16'h0004);
            checkOutput("stall_instr", bus.if_instr, memWord(16'h0004));
            checkOutput("stall_count", bus.accept_count, 16'd2);
        end
        sbQueue.push_back(16'h0004);
        sbQueue.push_back(16'h0006);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        sbQueue.push_back(16'h0000);
        sbQueue.push_back(16'h0002);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
        checkOutput("redirect_kill", {15'd0, bus.if_valid}, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("redirect_bubble", {15'd0, bus.if_valid}, 16'h0000);
        checkOutput("redirect_addr", bus.imem_addr, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("count_after_redirect", bus.accept_count, 16'd6);
        checkOutput("halt_entry_pc", bus.if_pc, 16'h0004);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
            checkOutput("halt_valid", {15'd0, bus.if_valid}, 16'h0000);
            checkOutput("halt_addr", bus.imem_addr, 16'h0006);
        end

        sbQueue.push_back(16'h0010);
        sbQueue.push_back(16'h0012);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0);
        checkOutput("halt_redirect_valid", {15'd0, bus.if_valid}, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("halt_bubble", {15'd0, bus.if_valid}, 16'h0000);
        checkOutput("halt_bubble_addr", bus.imem_addr, 16'h0010);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        sbQueue.push_back(16'hFFFE);
        sbQueue.push_back(16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        checkOutput("wrap_kill", {15'd0, bus.if_valid}, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrap_addr", bus.imem_addr, 16'hFFFE);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrap_next_addr", bus.imem_addr, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("pre_reset_pc", bus.if_pc, 16'h0002);
        checkOutput("count_before_reset", bus.accept_count, 16'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("reset_held_valid", {15'd0, bus.if_valid}, 16'h0000);
        checkOutput("reset_held_addr", bus.imem_addr, 16'h0000);

        sbQueue.push_back(16'h0000);
        sbQueue.push_back(16'h0002);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("post_reset_valid", {15'd0, bus.if_valid}, 16'h0000);
        checkOutput("post_reset_count", bus.accept_count, 16'd0);
        checkOutput("post_reset_addr", bus.imem_addr, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("final_count", bus.accept_count, 16'd2);
        checkOutput("sb_drained", 16'(sbQueue.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
